// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the direct-mapped instruction cache.
package icache_pkg;
  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;
  localparam int PROC_ADDR_W    = 30;
  localparam int MEM_ADDR_W     = 28;
  localparam int WORDS_PER_LINE = LINE_W / WORD_W;

  // Word address layout: [OFF_W-1:0] word offset, then index, then tag.
  localparam int OFF_LSB = 0;
  localparam int OFF_W   = 2;
  localparam int IDX_LSB = OFF_LSB + OFF_W;

  // A line viewed as words; word k sits at bits [32k+31:32k].
  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_t;

  // Tag width left over in a line address once the index is removed.
  function automatic int tag_w(input int idx_w);
    return MEM_ADDR_W - idx_w;
  endfunction
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one synchronous write port, combinational read.
module icache_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 8,
  parameter int IDX_W    = 3,
  parameter int TAG_W    = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_line
);
  logic [NUM_SETS-1:0]            valid_q;
  logic [NUM_SETS-1:0][TAG_W-1:0] tag_q;
  line_t                          data_q [NUM_SETS];

  // Valid bits are the only reset state; reset beats a coincident fill.
  always_ff @(posedge clk) begin
    if (!rst_n)     valid_q         <= '0;
    else if (wr_en) valid_q[wr_idx] <= 1'b1;
  end

  // Tag and data are plain storage, written on a fill and never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: hit compare, miss FSM, line refill, counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   proc_ren,
  input  logic                   proc_wen,
  input  logic [PROC_ADDR_W-1:0] proc_addr,
  input  logic [WORD_W-1:0]      proc_wdata,
  output logic [WORD_W-1:0]      proc_rdata,
  output logic                   proc_stall,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ready,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);
  localparam int IDX_W   = $clog2(NUM_SETS);
  localparam int TAG_W   = tag_w(IDX_W);
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  state_t                state;
  logic [MEM_ADDR_W-1:0] miss_line;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [OFF_W-1:0]      req_off;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  line_t                 rd_line;
  logic                  hit;
  logic                  fill;
  logic                  unused_ok;

  // Writes are not supported; these inputs are deliberately dropped.
  assign unused_ok = ^{proc_wen, proc_wdata};

  assign req_off = proc_addr[OFF_LSB +: OFF_W];
  assign req_idx = proc_addr[IDX_LSB +: IDX_W];
  assign req_tag = proc_addr[TAG_LSB +: TAG_W];

  assign hit  = rd_valid && (rd_tag == req_tag);
  assign fill = (state == FETCH) && mem_ready;

  icache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill),
    .wr_idx   (miss_line[0 +: IDX_W]),
    .wr_tag   (miss_line[IDX_W +: TAG_W]),
    .wr_line  (mem_rdata)
  );

  // Selected word is always driven; it is only meaningful on a hit.
  assign proc_rdata = rd_line[req_off];
  // Stall the whole fill, and in IDLE only when a read misses.
  assign proc_stall = (state == FETCH) || (proc_ren && !hit);

  // miss_line doubles as the registered line address, so it is stable through FETCH.
  assign mem_addr  = miss_line;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

  // Miss FSM with registered mem_read and the hit/miss counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      miss_line <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (proc_ren) begin
            if (hit) begin
              hit_cnt <= hit_cnt + 32'd1;
            end else begin
              miss_line <= proc_addr[PROC_ADDR_W-1:IDX_LSB];
              miss_cnt  <= miss_cnt + 32'd1;
              mem_read  <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          // proc_addr is ignored here; the fill always lands on miss_line.
          if (mem_ready) begin
            mem_read <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          mem_read <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed table, corner sequences, random vs. reference model.
module tb_icache_dm;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_ren = 1'b0;
  logic         proc_wen = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  always #5 clk = ~clk;

  icache_dm #(.NUM_SETS(8)) dut (
    .clk(clk), .rst_n(rst_n), .proc_ren(proc_ren), .proc_wen(proc_wen),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
    .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: cache contents as plain arrays, plus "waiting for line" bookkeeping.
  bit          m_valid [8];
  logic [24:0] m_tag   [8];
  logic [31:0] m_data  [8][4];
  bit          m_fetch;
  logic [27:0] m_line;
  int          m_fcnt;
  int          m_lat;
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  bit          m_addr_known;

  // Values sampled mid-cycle by the last call of cyc.
  logic        s_stall;
  logic        s_mread;
  logic [31:0] s_rdata;

  typedef struct {
    bit           ren;
    logic [29:0]  addr;
    bit           rdy;
    logic [127:0] mdata;
    bit           exp_stall;
    bit           exp_mread;
    bit           chk_rd;
    logic [31:0]  exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mem_line(input logic [27:0] line);
    logic [127:0] r;
    for (int k = 0; k < 4; k++)
      r[32*k +: 32] = {line, k[1:0], 2'b10} ^ 32'hC3A5_0F1E;
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) m_valid[s] = 1'b0;
    m_fetch      = 1'b0;
    m_line       = '0;
    m_fcnt       = 0;
    m_hits       = '0;
    m_misses     = '0;
    m_addr_known = 1'b1;
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model, take the edge.
  task automatic cyc(input bit ren, input bit wen, input logic [29:0] addr,
                     input bit rst, input bit rdy, input logic [127:0] mdata);
    logic [2:0] i;
    bit         hit;
    proc_ren   = ren;
    proc_wen   = wen;
    proc_addr  = addr;
    proc_wdata = $urandom;
    rst_n      = rst;
    mem_ready  = rdy;
    mem_rdata  = mdata;
    @(negedge clk);
    i   = addr[4:2];
    hit = m_valid[i] && (m_tag[i] == addr[29:5]);
    s_stall = proc_stall;
    s_mread = mem_read;
    s_rdata = proc_rdata;
    chk("stall", proc_stall, m_fetch || (ren && !hit));
    chk("mem_read", mem_read, m_fetch);
    if (m_fetch || m_addr_known) chk("mem_addr", mem_addr, m_line);
    chk("mem_write", mem_write, 1'b0);
    if (!m_fetch && ren && hit) chk("rdata", proc_rdata, m_data[i][addr[1:0]]);
    chk("hit_cnt", hit_cnt, m_hits);
    chk("miss_cnt", miss_cnt, m_misses);
    if (!rst) begin
      model_reset();
    end else if (m_fetch) begin
      m_fcnt++;
      if (rdy) begin
        for (int k = 0; k < 4; k++) m_data[m_line[2:0]][k] = mdata[32*k +: 32];
        m_tag[m_line[2:0]]   = m_line[27:3];
        m_valid[m_line[2:0]] = 1'b1;
        m_fetch = 1'b0;
      end
    end else if (ren) begin
      if (hit) m_hits++;
      else begin
        m_misses++;
        m_fetch      = 1'b1;
        m_line       = addr[29:2];
        m_fcnt       = 0;
        m_lat        = $urandom_range(1, 4);
        m_addr_known = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Keep requesting addr until the pending fill lands (memory answers after m_lat cycles).
  task automatic drain(input logic [29:0] addr);
    for (int g = 0; g < 16 && m_fetch; g++)
      cyc(1'b1, 1'b0, addr, 1'b1, m_fcnt == m_lat - 1, mem_line(m_line));
  endtask

  // Issue a missing read, report the line address presented to memory, complete the fill.
  task automatic miss_fill(input logic [29:0] addr, output logic [27:0] seen);
    cyc(1'b1, 1'b0, addr, 1'b1, 1'b0, '0);
    seen = mem_addr;
    drain(addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl [8];
    logic [27:0] a0, a1, a2;
    logic [31:0] h0, mi0;
    logic [29:0] cur;

    // Power-up reset: outputs are unknown before the first reset edge, so no checks here.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Cold miss on 0x10, 3-cycle memory, then sequential hits across the line.
    tbl[0] = '{1'b1, 30'h10, 1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 30'h10, 1'b0, 128'h0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 30'h10, 1'b0, 128'h0, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 30'h10, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA}, 1'b1, 1'b1, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 30'h10, 1'b0, 128'h0, 1'b0, 1'b0, 1'b1, 32'hA};
    tbl[5] = '{1'b1, 30'h11, 1'b0, 128'h0, 1'b0, 1'b0, 1'b1, 32'hB};
    tbl[6] = '{1'b1, 30'h12, 1'b0, 128'h0, 1'b0, 1'b0, 1'b1, 32'hC};
    tbl[7] = '{1'b1, 30'h13, 1'b0, 128'h0, 1'b0, 1'b0, 1'b1, 32'hD};

    // Reset state with an idle request.
    cyc(1'b0, 1'b0, 30'h0, 1'b1, 1'b0, '0);
    chk("reset mem_read", s_mread, 1'b0);
    chk("reset mem_addr", mem_addr, 28'h0);
    chk("reset hit_cnt", hit_cnt, 32'h0);

    for (int v = 0; v < 8; v++) begin
      cyc(tbl[v].ren, 1'b0, tbl[v].addr, 1'b1, tbl[v].rdy, tbl[v].mdata);
      chk($sformatf("tbl%0d stall", v), s_stall, tbl[v].exp_stall);
      chk($sformatf("tbl%0d mem_read", v), s_mread, tbl[v].exp_mread);
      if (tbl[v].chk_rd) chk($sformatf("tbl%0d rdata", v), s_rdata, tbl[v].exp_rd);
      if (v == 0) chk("cold mem_addr", mem_addr, 28'h4);
    end
    chk("cold miss_cnt", miss_cnt, 32'd1);
    chk("seq hit_cnt", hit_cnt, 32'd4);

    // Conflict eviction in set 0.
    mi0 = m_misses;
    miss_fill(30'h00, a0);
    miss_fill(30'h20, a1);
    miss_fill(30'h00, a2);
    chk("evict addr0", a0, 28'h0);
    chk("evict addr1", a1, 28'h8);
    chk("evict addr2", a2, 28'h0);
    chk("evict misses", miss_cnt - mi0, 32'd3);

    // Request address moves during FETCH; fill still targets the original line.
    cyc(1'b1, 1'b0, 30'h40, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 30'h80, 1'b1, 1'b0, '0);
    chk("moved mem_addr", mem_addr, 28'h10);
    cyc(1'b1, 1'b0, 30'h80, 1'b1, 1'b1, mem_line(28'h10));
    cyc(1'b1, 1'b0, 30'h80, 1'b1, 1'b0, '0);
    chk("moved re-miss stall", s_stall, 1'b1);
    chk("moved new mem_addr", mem_addr, 28'h20);
    drain(30'h80);

    // Reset while filling, then a stray mem_ready after release.
    cyc(1'b1, 1'b0, 30'h44, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 30'h44, 1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, 30'h44, 1'b0, 1'b0, '0);
    chk("rst-fetch mem_read", mem_read, 1'b0);
    cyc(1'b0, 1'b0, 30'h44, 1'b1, 1'b1, mem_line(28'h11));
    chk("stray stall", s_stall, 1'b0);
    chk("stray mem_read", mem_read, 1'b0);
    cyc(1'b1, 1'b0, 30'h10, 1'b1, 1'b0, '0);
    chk("post-reset re-miss", s_stall, 1'b1);
    drain(30'h10);

    // Writes are ignored.
    h0  = m_hits;
    mi0 = m_misses;
    cyc(1'b0, 1'b1, 30'h10, 1'b1, 1'b0, '0);
    chk("wen stall", s_stall, 1'b0);
    chk("wen mem_read", mem_read, 1'b0);
    chk("wen hit_cnt", hit_cnt, h0);
    chk("wen miss_cnt", miss_cnt, mi0);

    // Random traffic over a small address pool so hits, conflicts and refills all occur.
    cur = '0;
    for (int n = 0; n < 1500; n++) begin
      bit ren, wen, rst, rdy;
      if (!m_fetch || $urandom_range(0, 3) == 0)
        cur = {25'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      ren = m_fetch ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) != 0);
      wen = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 149) != 0);
      rdy = m_fetch ? (m_fcnt == m_lat - 1) : ($urandom_range(0, 19) == 0);
      cyc(ren, wen, cur, rst, rdy, m_fetch ? mem_line(m_line) : 128'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
